// File: rtl/yari_mem_arbiter_if.sv
// Bundle of the I-side, D-side and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface yari_mem_arbiter_if #(
    parameter int AW = 32
);
    logic [AW-1:0] i_addr;
    logic          i_read;
    logic          i_wait;
    logic [31:0]   i_readdata;
    logic          i_readdatavalid;

    logic [AW-1:0] d_addr;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_writedata;
    logic [3:0]    d_byteena;
    logic          d_wait;
    logic [31:0]   d_readdata;
    logic          d_readdatavalid;

    logic [AW-1:0] m_addr;
    logic          m_read;
    logic          m_write;
    logic [31:0]   m_writedata;
    logic [3:0]    m_byteena;
    logic          m_wait;
    logic [31:0]   m_readdata;
    logic          m_readdatavalid;

    modport slave (
        input  i_addr, i_read,
        output i_wait, i_readdata, i_readdatavalid,
        input  d_addr, d_read, d_write, d_writedata, d_byteena,
        output d_wait, d_readdata, d_readdatavalid,
        output m_addr, m_read, m_write, m_writedata, m_byteena,
        input  m_wait, m_readdata, m_readdatavalid
    );

    modport master (
        output i_addr, i_read,
        input  i_wait, i_readdata, i_readdatavalid,
        output d_addr, d_read, d_write, d_writedata, d_byteena,
        input  d_wait, d_readdata, d_readdatavalid,
        input  m_addr, m_read, m_write, m_writedata, m_byteena,
        output m_wait, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/yari_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Combinational request path, wait-state lock, in-order tag FIFO routing.
module yari_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int AW = 32
) (
    input logic               clock,
    input logic               rst,
    yari_mem_arbiter_if.slave bus
);
    localparam int PW = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        LK_NONE,
        LK_I,
        LK_D
    } lock_t;

    lock_t                      lock_q;
    lock_t                      lock_n;
    logic                       last_d;
    logic [MAX_OUTSTANDING-1:0] tags;
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [PW:0]                count;

    logic          i_req;
    logic          d_req;
    logic          grant_d;
    logic          g_req;
    logic          g_read;
    logic          g_write;
    logic          full;
    logic          empty;
    logic          stall;
    logic          accept;
    logic          push;
    logic          pop;
    logic          head;
    logic [AW-1:0] addr_sel;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign full  = count == (PW+1)'(MAX_OUTSTANDING);
    assign empty = count == '0;
    assign head  = tags[rptr];

    // Grant: lock owner first, else lone requester, else round-robin
    always_comb begin
        grant_d = 1'b0;
        if (lock_q == LK_D) begin
            grant_d = 1'b1;
        end else if (lock_q == LK_I) begin
            grant_d = 1'b0;
        end else if (d_req & i_req) begin
            grant_d = ~last_d;
        end else begin
            grant_d = d_req;
        end
    end

    assign g_req   = grant_d ? d_req : i_req;
    assign g_write = grant_d & bus.d_write;
    assign g_read  = grant_d ? (bus.d_read & ~bus.d_write)
                             : bus.i_read;
    // A read into a full FIFO is only safe when a tag retires
    assign stall   = g_read & full & ~bus.m_readdatavalid;
    assign accept  = rst & g_req & ~bus.m_wait & ~stall;
    assign push    = accept & g_read;
    assign pop     = rst & bus.m_readdatavalid & ~empty;

    assign addr_sel        = grant_d ? bus.d_addr : bus.i_addr;
    assign bus.m_addr      = addr_sel;
    assign bus.m_read      = rst & g_read & ~stall;
    assign bus.m_write     = rst & g_write;
    assign bus.m_writedata = bus.d_writedata;
    assign bus.m_byteena   = grant_d ? bus.d_byteena : 4'hF;

    assign bus.i_wait = ~rst | grant_d | bus.m_wait | stall;
    assign bus.d_wait = ~rst | ~grant_d | bus.m_wait | stall;

    assign bus.i_readdata      = bus.m_readdata;
    assign bus.d_readdata      = bus.m_readdata;
    assign bus.i_readdatavalid = pop & ~head;
    assign bus.d_readdatavalid = pop & head;

    // Lock next state: hold the owner across wait states
    always_comb begin
        lock_n = lock_q;
        if (lock_q != LK_NONE) begin
            if (accept | ~g_req) begin
                lock_n = LK_NONE;
            end
        end else if (g_req & bus.m_wait) begin
            lock_n = grant_d ? LK_D : LK_I;
        end
    end

    // Lock state and round-robin history
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lock_q <= LK_NONE;
            last_d <= 1'b0;
        end else begin
            lock_q <= lock_n;
            if (accept) begin
                last_d <= grant_d;
            end
        end
    end

    // Tag FIFO: one bit per outstanding read, 1 = D side
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tags  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tags[wptr] <= grant_d;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_yari_mem_arbiter.sv
// Self-checking bench: directed steps then random traffic,
// checked against a queue-based reference model.
module tb_yari_mem_arbiter;
    localparam int MAXO = 4;
    localparam int AW   = 32;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    yari_mem_arbiter_if #(.AW(AW)) bus ();

    yari_mem_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .AW(AW)
    ) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    int pushes     = 0;

    bit m_last_d = 1'b0;
    bit m_lock_v = 1'b0;
    bit m_lock_d = 1'b0;
    bit tagq[$];

    bit acc_i;
    bit acc_d;

    logic [31:0] s_addr;
    logic        s_mr;
    logic        s_mw;
    logic        s_iw;
    logic        s_dw;
    logic        s_irv;
    logic        s_drv;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance it
    task automatic step();
        bit ireq, dreq, gd, req, rd, stl, popv, acc, hd;
        @(negedge clock);
        if (bus.d_read && bus.d_write) begin
            miscompares++;
            $error("FAIL d_read_and_write observed=1 expected=0");
        end
        ireq = bus.i_read;
        dreq = bus.d_read || bus.d_write;
        if (m_lock_v) gd = m_lock_d;
        else if (ireq && dreq) gd = !m_last_d;
        else gd = dreq;
        req  = gd ? dreq : ireq;
        rd   = gd ? (bus.d_read && !bus.d_write) : bus.i_read;
        stl  = rd && (tagq.size() >= MAXO) && !bus.m_readdatavalid;
        popv = rst && bus.m_readdatavalid && (tagq.size() > 0);
        hd   = (tagq.size() > 0) ? tagq[0] : 1'b0;
        acc  = rst && req && !bus.m_wait && !stl;

        s_addr = bus.m_addr;
        s_mr   = bus.m_read;
        s_mw   = bus.m_write;
        s_iw   = bus.i_wait;
        s_dw   = bus.d_wait;
        s_irv  = bus.i_readdatavalid;
        s_drv  = bus.d_readdatavalid;

        chk("m_read", 32'(s_mr), 32'(rst && rd && !stl));
        chk("m_write", 32'(s_mw), 32'(rst && gd && bus.d_write));
        chk("i_wait", 32'(s_iw),
            32'(!rst || gd || bus.m_wait || stl));
        chk("d_wait", 32'(s_dw),
            32'(!rst || !gd || bus.m_wait || stl));
        chk("i_rdv", 32'(s_irv), 32'(popv && !hd));
        chk("d_rdv", 32'(s_drv), 32'(popv && hd));
        chk("i_rdata", bus.i_readdata, bus.m_readdata);
        chk("d_rdata", bus.d_readdata, bus.m_readdata);
        if (rst && (s_mr || s_mw)) begin
            chk("m_addr", s_addr, gd ? bus.d_addr : bus.i_addr);
            chk("m_be", 32'(bus.m_byteena),
                32'(gd ? bus.d_byteena : 4'hF));
        end
        if (rst && gd && bus.d_write) begin
            chk("m_wdata", bus.m_writedata, bus.d_writedata);
        end

        @(posedge clock);
        if (!rst) begin
            tagq.delete();
            m_lock_v = 1'b0;
            m_last_d = 1'b0;
        end else begin
            if (popv) void'(tagq.pop_front());
            if (acc && rd) begin
                tagq.push_back(gd);
                pushes++;
            end
            if (m_lock_v) begin
                if (acc || !req) m_lock_v = 1'b0;
            end else if (req && bus.m_wait) begin
                m_lock_v = 1'b1;
                m_lock_d = gd;
            end
            if (acc) m_last_d = gd;
        end
        acc_i = acc && !gd;
        acc_d = acc && gd;
        #1;
    endtask

    task automatic idle();
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.m_wait = 1'b0;
        bus.m_readdatavalid = 1'b0;
    endtask

    logic [31:0] addr_tab [4];
    bit          d_tab [4];

    initial begin
        bus.i_addr = '0;
        bus.d_addr = '0;
        bus.d_writedata = '0;
        bus.d_byteena = 4'h0;
        bus.m_readdata = '0;
        idle();

        // reset state
        step();
        chk("rst_mread", 32'(s_mr), 32'h0);
        chk("rst_iwait", 32'(s_iw), 32'h1);
        chk("rst_dwait", 32'(s_dw), 32'h1);
        rst = 1'b1;
        step();

        // lone I read, response two cycles later
        bus.i_read = 1'b1;
        bus.i_addr = 32'hBFC0_0000;
        step();
        chk("t1_mread", 32'(s_mr), 32'h1);
        chk("t1_addr", s_addr, 32'hBFC0_0000);
        chk("t1_iwait", 32'(s_iw), 32'h0);
        bus.i_read = 1'b0;
        step();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata = 32'h3C1D_A000;
        step();
        chk("t1_irv", 32'(s_irv), 32'h1);
        chk("t1_drv", 32'(s_drv), 32'h0);
        bus.m_readdatavalid = 1'b0;
        step();
        chk("t1_irv_once", 32'(s_irv), 32'h0);

        // both read for 4 cycles: D, I, D, I
        addr_tab = '{32'h200, 32'h100, 32'h200, 32'h100};
        d_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_grant", s_addr, addr_tab[k]);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = 32'h1000 + 32'(k);
            step();
            chk("t2_route_d", 32'(s_drv), 32'(d_tab[k]));
            chk("t2_route_i", 32'(s_irv), 32'(!d_tab[k]));
        end
        idle();

        // D write held by m_wait while I keeps requesting
        bus.d_write = 1'b1;
        bus.d_addr = 32'h10;
        bus.d_writedata = 32'hDEAD_BEEF;
        bus.d_byteena = 4'b0011;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        bus.m_wait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.m_wait = 1'b0;
            step();
            chk("t3_mwrite", 32'(s_mw), 32'h1);
            chk("t3_addr", s_addr, 32'h10);
            chk("t3_iwait", 32'(s_iw), 32'h1);
        end
        chk("t3_dacc", 32'(s_dw), 32'h0);
        bus.d_write = 1'b0;
        step();
        chk("t3_igrant", s_addr, 32'h100);
        chk("t3_iwait2", 32'(s_iw), 32'h0);
        chk("t3_tags", 32'(tagq.size()), 32'h1);
        idle();
        bus.m_readdatavalid = 1'b1;
        step();
        idle();

        // fill the FIFO, then a 5th read
        bus.i_read = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            bus.i_addr = 32'h400 + 32'(4 * k);
            step();
        end
        bus.i_addr = 32'h500;
        step();
        chk("t4_full_iwait", 32'(s_iw), 32'h1);
        chk("t4_full_mread", 32'(s_mr), 32'h0);
        bus.m_readdatavalid = 1'b1;
        step();
        chk("t4_retire_iwait", 32'(s_iw), 32'h0);
        chk("t4_retire_mread", 32'(s_mr), 32'h1);
        chk("t4_count", 32'(tagq.size()), 32'(MAXO));
        bus.i_read = 1'b0;
        for (int k = 0; k < MAXO; k++) begin
            step();
            chk("t4_drain", 32'(s_irv), 32'h1);
        end
        idle();

        // reset mid-wait with two reads outstanding
        bus.i_read = 1'b1;
        step();
        step();
        bus.m_wait = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_mread_now", 32'(bus.m_read), 32'h0);
        chk("t5_iwait_now", 32'(bus.i_wait), 32'h1);
        chk("t5_dwait_now", 32'(bus.d_wait), 32'h1);
        step();
        rst = 1'b1;
        idle();
        bus.m_readdatavalid = 1'b1;
        step();
        chk("t5_stray_i", 32'(s_irv), 32'h0);
        chk("t5_stray_d", 32'(s_drv), 32'h0);
        idle();

        // first tie after reset goes to D
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        step();
        chk("t5_first_tie", s_addr, bus.d_addr);
        idle();
        bus.m_readdatavalid = 1'b1;
        step();
        idle();

        // random traffic until pointers have wrapped at least twice
        pushes = 0;
        for (int c = 0; c < 2000 && pushes < 3 * MAXO + 2; c++) begin
            if (!bus.i_read && $urandom_range(0, 1) == 1) begin
                bus.i_read = 1'b1;
                bus.i_addr = $urandom;
            end
            if (!(bus.d_read || bus.d_write) &&
                $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 2) == 0) bus.d_write = 1'b1;
                else bus.d_read = 1'b1;
                bus.d_addr = $urandom;
                bus.d_writedata = $urandom;
                bus.d_byteena = 4'($urandom);
            end
            bus.m_wait = ($urandom_range(0, 3) == 0);
            bus.m_readdatavalid = (tagq.size() > 0) &&
                                  ($urandom_range(0, 1) == 1);
            bus.m_readdata = $urandom;
            step();
            if (acc_i) bus.i_read = 1'b0;
            if (acc_d) begin
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
            end
        end
        chk("rand_wraps", 32'(pushes >= 2 * MAXO), 32'h1);
        for (int c = 0; c < 200 && (bus.i_read || bus.d_read ||
                                     bus.d_write); c++) begin
            bus.m_wait = 1'b0;
            bus.m_readdatavalid = 1'b0;
            step();
            if (acc_i) bus.i_read = 1'b0;
            if (acc_d) begin
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
            end
        end
        idle();
        for (int c = 0; c < 4 * MAXO && tagq.size() > 0; c++) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = $urandom;
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
